// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential multiplier and its divider companion.
// Contents:
//   state_t     FSM encoding (ST_IDLE, ST_CALC, ST_DONE); the divider uses the same values
//   W_DEFAULT   default operand width
//   cnt_width() bit-counter width, chosen so that 2**cnt_width(w) > w
package mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned W_DEFAULT = 16;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_seq_datapath.sv
// Shift-add datapath for the sequential multiplier.
// Holds the shifted multiplicand (a_q), the remaining multiplier bits (b_q), the partial
// product (acc_q) and the step counter (cnt_q). Each step retires one multiplier bit.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   load       capture a/b and clear acc/cnt
//   step       perform one add-shift step
//   a, b       operands (W bits)
//   acc_next   partial product including the current step (2*W bits)
//   finish     current step is the final one
// Build option: MULT_EARLY_EXIT_EN also finishes once no set multiplier bits remain.
module mult_seq_datapath #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] acc_next,
  output logic           finish
);

  logic [2*W-1:0] a_q, acc_q;
  logic [W-1:0]   b_q;
  logic [CNT_W-1:0] cnt_q;

  assign acc_next = b_q[0] ? acc_q + a_q : acc_q;

`ifdef MULT_EARLY_EXIT_EN
  // Nothing above bit 0 remains, so this step (or no step when b_q==0) completes the product.
  assign finish = (cnt_q == CNT_W'(W - 1)) || (b_q[W-1:1] == '0);
`else
  assign finish = (cnt_q == CNT_W'(W - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= {{W{1'b0}}, a};
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= acc_next;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/multiplier_seq_board.sv
// Sequential shift-add unsigned multiplier with start/done handshake.
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   start  request pulse, honoured only in ST_IDLE
//   a, b   multiplicand / multiplier, captured on the accepting edge
//   busy   high in ST_CALC and ST_DONE
//   done   one-cycle completion strobe
//   y      product (2*W bits), held until the next completion
// Build option: MULT_EARLY_EXIT_EN ends the calculation once no multiplier bits remain.
module multiplier_seq_board
  import mult_seq_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned CNT_W = cnt_width(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] y
);

  state_t state_q, state_d;
  logic [2*W-1:0] y_q, y_d;
  logic [2*W-1:0] acc_next;
  logic           load, step, finish;

  mult_seq_datapath #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .a        (a),
    .b        (b),
    .acc_next (acc_next),
    .finish   (finish)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (finish) begin
          y_d     = acc_next;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  // Decoded from state so reset clears both strobes immediately.
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign y    = y_q;

endmodule

// File: tb/tb_multiplier_seq_board.sv
// Self-checking bench for multiplier_seq_board (W=16, 10 ns clock).
// Expected products and completion cycles are queued at issue time and compared
// whenever done is seen.
module tb_multiplier_seq_board;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done;
  logic [2*W-1:0] y;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  logic [2*W-1:0] y_model = '0;
  logic           prev_done = 1'b0;

  multiplier_seq_board #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Edges from acceptance to the edge that raises done.
  function automatic int latency(input logic [W-1:0] bv);
`ifdef MULT_EARLY_EXIT_EN
    int hi;
    hi = 0;
    for (int i = 0; i < int'(W); i++) if (bv[i]) hi = i;
    return 1 + hi;
`else
    return int'(W);
`endif
  endfunction

  function automatic exp_t mk(input logic [W-1:0] av, input logic [W-1:0] bv, input int c);
    exp_t e;
    e.prod = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
    e.cyc  = c + 1 + latency(bv);
    return e;
  endfunction

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (prev_done) begin
        check("done_width", 64'(done), 64'd0);
        check("busy_fall", 64'(busy), 64'd0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", 64'(y), 64'(e.prod));
          check("latency", 64'(cyc), 64'(e.cyc));
          y_model = e.prod;
        end
      end else begin
        check("y_hold", 64'(y), 64'(y_model));
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(posedge clk); #1;
    a = av; b = bv; start = 1'b1;
    sb.push_back(mk(av, bv, cyc));
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_empty(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    // 1: reset state, then 3*5
    #1;
    check("rst_y", 64'(y), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("post_rst_y", 64'(y), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    issue(16'd3, 16'd5);
    wait_empty(40);

    // 2: maximum operands
    issue(16'hFFFF, 16'hFFFF);
    wait_empty(40);

    // 3: zero multiplier, and a small multiplier that allows an early finish
    issue(16'd1234, 16'd0);
    wait_empty(40);
    issue(16'd7, 16'h0004);
    wait_empty(40);

    // 4: start while busy is ignored
    issue(16'd10, 16'd10);
    repeat (4) @(posedge clk);
    #1;
    a = 16'd2; b = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_empty(40);
    repeat (40) @(negedge clk);

    // 5: reset mid-operation
    issue(16'd100, 16'd200);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    y_model = '0;
    sb.delete();
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_y", 64'(y), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    issue(16'd100, 16'd200);
    wait_empty(40);

    // 6: back-to-back with start held high
    @(posedge clk); #1;
    a = 16'd6; b = 16'd7; start = 1'b1;
    begin
      exp_t e1, e2;
      e1 = mk(16'd6, 16'd7, cyc);
      sb.push_back(e1);
      @(posedge clk); #1;
      a = 16'd9; b = 16'd9;
      e2 = mk(16'd9, 16'd9, e1.cyc + 1);
      sb.push_back(e2);
    end
    wait_empty(60);
    start = 1'b0;

    // a few random operands
    for (int i = 0; i < 4; i++) begin
      issue(W'($urandom), W'($urandom));
      wait_empty(40);
    end
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
